// File: rtl/zero_pkg.sv
// zero_pkg: shared word width, word type and checker state encoding for the
// test-program executor back end.
package zero_pkg;

    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] mem_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } out_check_state_t;

    // True when a captured word differs from its expected value
    function automatic logic wordsDiffer(input mem_word_t observed, input mem_word_t expected);
        return (observed != expected);
    endfunction

endpackage

// File: rtl/out_buffer.sv
// out_buffer: circular capture RAM for executor `out` words. Tracks the write
// position, a fill count that saturates at the depth, and a sticky overflow flag.
module out_buffer
    import zero_pkg::*;
#(
    parameter int NOut       = 100,
    parameter int AddrWidth  = (NOut > 1) ? $clog2(NOut) : 1,
    parameter int CountWidth = $clog2(NOut + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wrEn,
    input  logic [MemoryElementWidth-1:0] wrData,
    input  logic [AddrWidth-1:0]          rdAddr,
    output logic [MemoryElementWidth-1:0] rdData,
    output logic [AddrWidth-1:0]          wrPtr,
    output logic [CountWidth-1:0]         count,
    output logic                          overflow
);

    localparam logic [AddrWidth-1:0]  LastPtr = AddrWidth'(NOut - 1);
    localparam logic [CountWidth-1:0] Full    = CountWidth'(NOut);

    mem_word_t mem_r [NOut];

    // Storage array; contents are only meaningful up to the fill count
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem_r[wrPtr] <= wrData;
        end
    end

    assign rdData = mem_r[rdAddr];

    // Write pointer wraps at the depth; count saturates and a write when full is sticky overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr    <= {AddrWidth{1'b0}};
            count    <= {CountWidth{1'b0}};
            overflow <= 1'b0;
        end else if (wrEn) begin
            wrPtr <= (wrPtr == LastPtr) ? {AddrWidth{1'b0}} : wrPtr + AddrWidth'(1);
            if (count == Full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CountWidth'(1);
            end
        end
    end

endmodule

// File: rtl/out_channel_checker.sv
// out_channel_checker: captures executor `out` words, compares them against a
// loaded expected table once the program halts, reports the verdict and then
// streams the captured words (oldest first) to the host over valid/ready.
module out_channel_checker
    import zero_pkg::*;
#(
    parameter int NOut          = 100,
    parameter int NExpected     = 1,
    parameter int ExpIndexWidth = (NExpected > 1) ? $clog2(NExpected) : 1,
    parameter int IndexWidth    = (NOut > 1) ? $clog2(NOut) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    input  logic                          expValid,
    input  logic [ExpIndexWidth-1:0]      expIndex,
    input  logic [MemoryElementWidth-1:0] expData,
    input  logic                          progFinished,
    output logic                          drainValid,
    input  logic                          drainReady,
    output logic [MemoryElementWidth-1:0] drainData,
    output logic                          finished,
    output logic                          success,
    output logic [IndexWidth-1:0]         mismatchIndex,
    output logic                          overflow
);

    localparam int CountWidth = $clog2(NOut + 1);
    localparam logic [CountWidth-1:0] NExpCount = CountWidth'(NExpected);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(NExpected - 1);
    localparam logic [IndexWidth-1:0] LastIdx   = IndexWidth'(NExpected - 1);
    localparam logic [IndexWidth-1:0] LastPtr   = IndexWidth'(NOut - 1);

    out_check_state_t          state_r;
    mem_word_t                 expTable_r [NExpected];
    logic                      finPending_r;
    logic                      mismatchSeen_r;
    logic                      drainStarted_r;
    logic [IndexWidth-1:0]     checkIdx_r;
    logic [IndexWidth-1:0]     drainPtr_r;
    logic [CountWidth-1:0]     drainLeft_r;

    logic                      wrEn_s;
    logic [IndexWidth-1:0]     rdAddr_s;
    mem_word_t                 rdData_s;
    logic [IndexWidth-1:0]     wrPtr_s;
    logic [CountWidth-1:0]     count_s;
    logic [ExpIndexWidth-1:0]  checkExpIdx_s;
    logic                      cmpMismatch_s;
    logic                      anyMismatch_s;
    logic [IndexWidth-1:0]     countClamp_s;
    logic [IndexWidth-1:0]     drainPtrNext_s;
    logic                      drainLoad_s;

    out_buffer #(
        .NOut       (NOut),
        .AddrWidth  (IndexWidth),
        .CountWidth (CountWidth)
    ) u_out_buffer (
        .clock    (clock),
        .reset    (reset),
        .wrEn     (wrEn_s),
        .wrData   (outData),
        .rdAddr   (rdAddr_s),
        .rdData   (rdData_s),
        .wrPtr    (wrPtr_s),
        .count    (count_s),
        .overflow (overflow)
    );

    // Capture gating, read-port sharing between check and drain, and the current compare verdict
    always_comb begin
        wrEn_s         = 1'b0;
        rdAddr_s       = checkIdx_r;
        checkExpIdx_s  = ExpIndexWidth'(checkIdx_r);
        cmpMismatch_s  = 1'b0;
        anyMismatch_s  = 1'b0;
        countClamp_s   = {IndexWidth{1'b0}};
        drainPtrNext_s = {IndexWidth{1'b0}};
        drainLoad_s    = 1'b0;

        if (outValid && ((state_r == IDLE) || (state_r == CAPTURE))) begin
            wrEn_s = 1'b1;
        end else begin
            wrEn_s = 1'b0;
        end

        if (state_r == DONE) begin
            rdAddr_s = drainPtr_r;
        end else begin
            rdAddr_s = checkIdx_r;
        end

        // An index that was never written counts as a mismatch
        if (CountWidth'(checkIdx_r) >= count_s) begin
            cmpMismatch_s = 1'b1;
        end else if (wordsDiffer(rdData_s, expTable_r[checkExpIdx_s])) begin
            cmpMismatch_s = 1'b1;
        end else begin
            cmpMismatch_s = 1'b0;
        end

        anyMismatch_s  = mismatchSeen_r || cmpMismatch_s;
        countClamp_s   = (count_s > LastCount) ? LastIdx : IndexWidth'(count_s);
        drainPtrNext_s = (drainPtr_r == LastPtr) ? {IndexWidth{1'b0}} : drainPtr_r + IndexWidth'(1);

        // Load the next word on drain start or when the host takes the current one
        if ((state_r == DONE) && (drainLeft_r != {CountWidth{1'b0}}) &&
            (!drainStarted_r || (drainValid && drainReady))) begin
            drainLoad_s = 1'b1;
        end else begin
            drainLoad_s = 1'b0;
        end
    end

    // Checker FSM: table load, capture, sequential compare, verdict and drain sequencing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            finPending_r   <= 1'b0;
            mismatchSeen_r <= 1'b0;
            drainStarted_r <= 1'b0;
            checkIdx_r     <= {IndexWidth{1'b0}};
            drainPtr_r     <= {IndexWidth{1'b0}};
            drainLeft_r    <= {CountWidth{1'b0}};
            drainValid     <= 1'b0;
            drainData      <= {MemoryElementWidth{1'b0}};
            finished       <= 1'b0;
            success        <= 1'b0;
            mismatchIndex  <= {IndexWidth{1'b0}};
            for (int i = 0; i < NExpected; i++) begin
                expTable_r[i] <= {MemoryElementWidth{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (expValid && (int'(expIndex) < NExpected)) begin
                        expTable_r[expIndex] <= expData;
                    end
                    if (outValid || progFinished) begin
                        state_r <= CAPTURE;
                    end
                    // A halt pulse seen here must not be lost on the way through CAPTURE
                    if (progFinished) begin
                        finPending_r <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (progFinished || finPending_r) begin
                        state_r        <= CHECK;
                        checkIdx_r     <= {IndexWidth{1'b0}};
                        mismatchSeen_r <= 1'b0;
                        finPending_r   <= 1'b0;
                    end
                end
                CHECK: begin
                    if (cmpMismatch_s && !mismatchSeen_r) begin
                        mismatchSeen_r <= 1'b1;
                        mismatchIndex  <= checkIdx_r;
                    end
                    if (checkIdx_r == LastIdx) begin
                        state_r        <= DONE;
                        finished       <= 1'b1;
                        success        <= !anyMismatch_s && (count_s == NExpCount) && !overflow;
                        // All compared words matched but the word count is wrong
                        if (!anyMismatch_s && (count_s != NExpCount)) begin
                            mismatchIndex <= countClamp_s;
                        end
                        drainPtr_r     <= overflow ? wrPtr_s : {IndexWidth{1'b0}};
                        drainLeft_r    <= count_s;
                        drainStarted_r <= 1'b0;
                    end else begin
                        checkIdx_r <= checkIdx_r + IndexWidth'(1);
                    end
                end
                DONE: begin
                    drainStarted_r <= 1'b1;
                    if (drainLoad_s) begin
                        drainValid  <= 1'b1;
                        drainData   <= rdData_s;
                        drainPtr_r  <= drainPtrNext_s;
                        drainLeft_r <= drainLeft_r - CountWidth'(1);
                    end else if (drainStarted_r && drainValid && drainReady) begin
                        drainValid <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_channel_checker.sv
// tb_out_channel_checker: scoreboard bench. Two checker instances (default
// sizing and a 4-deep / 3-expected one) share stimulus; the unused one is held
// in reset. Drain words are predicted when outputs are driven and compared as
// the host accepts them.
module tb_out_channel_checker;

    logic        clock = 1'b0;
    logic        rst0, rst1, sel;
    logic        outValid, expValid, progFinished, drainReady;
    logic [11:0] outData, expData;
    logic [1:0]  expIdx;

    logic        dv0, fin0, suc0, ovf0, dv1, fin1, suc1, ovf1;
    logic [11:0] dd0, dd1;
    logic [6:0]  mi0;
    logic [1:0]  mi1;

    logic        dv, fin, suc, ovf;
    logic [11:0] dd;
    logic [6:0]  mi;

    int passCount = 0;
    int checkCount = 0;
    int sbQ[$];

    always #5 clock = ~clock;

    out_channel_checker #(.NOut(100), .NExpected(1)) u0 (
        .clock(clock), .reset(rst0), .outValid(outValid), .outData(outData),
        .expValid(expValid), .expIndex(expIdx[0:0]), .expData(expData),
        .progFinished(progFinished), .drainValid(dv0), .drainReady(drainReady),
        .drainData(dd0), .finished(fin0), .success(suc0), .mismatchIndex(mi0),
        .overflow(ovf0)
    );

    out_channel_checker #(.NOut(4), .NExpected(3)) u1 (
        .clock(clock), .reset(rst1), .outValid(outValid), .outData(outData),
        .expValid(expValid), .expIndex(expIdx), .expData(expData),
        .progFinished(progFinished), .drainValid(dv1), .drainReady(drainReady),
        .drainData(dd1), .finished(fin1), .success(suc1), .mismatchIndex(mi1),
        .overflow(ovf1)
    );

    // Observe whichever instance the current scenario targets
    always_comb begin
        dv  = sel ? dv1  : dv0;
        fin = sel ? fin1 : fin0;
        suc = sel ? suc1 : suc0;
        ovf = sel ? ovf1 : ovf0;
        dd  = sel ? dd1  : dd0;
        mi  = sel ? {5'b0, mi1} : mi0;
    end

    task automatic checkVal(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic runProgram(input int s, input int nExp, input int nOut, input bit loadExp,
                              input logic [11:0] expPacked, input logic [31:0] wordsPacked,
                              input int nWords, input bit stall, input bit abortInCheck);
        int bm[100];
        int expv[3];
        int mCnt, wp, firstBad, expMi, lat, w, guard, xfers, stallCycles, held;
        bit mOv, expSuc;

        sbQ.delete();
        sel = (s != 0);
        @(negedge clock);
        rst0 = 1'b1; rst1 = 1'b1;
        outValid = 1'b0; expValid = 1'b0; progFinished = 1'b0; drainReady = 1'b1;
        #1;
        checkVal("rst_flags", int'({fin, suc, dv, ovf}), 0);
        checkVal("rst_index", int'(mi), 0);
        checkVal("rst_data", int'(dd), 0);
        @(negedge clock);
        if (s == 0) rst0 = 1'b0; else rst1 = 1'b0;

        for (int i = 0; i < 3; i++) expv[i] = loadExp ? int'(expPacked[4*i +: 4]) : 0;
        if (loadExp) begin
            for (int i = 0; i < nExp; i++) begin
                expValid = 1'b1; expIdx = 2'(i); expData = 12'(expv[i]);
                @(negedge clock);
            end
            expValid = 1'b0;
        end

        mCnt = 0; wp = 0; mOv = 1'b0;
        for (int i = 0; i < 100; i++) bm[i] = 0;
        for (int i = 0; i < nWords; i++) begin
            w = int'(wordsPacked[4*i +: 4]);
            outValid = 1'b1; outData = 12'(w);
            bm[wp] = w;
            wp = (wp + 1) % nOut;
            if (mCnt == nOut) mOv = 1'b1; else mCnt++;
            sbQ.push_back(w);
            if (sbQ.size() > nOut) void'(sbQ.pop_front());
            @(negedge clock);
        end
        outValid = 1'b0;

        progFinished = 1'b1;
        @(negedge clock);
        progFinished = 1'b0;
        lat = 1;

        if (abortInCheck) begin
            checkVal("pre_abort_ovf", int'(ovf), int'(mOv));
            if (s == 0) rst0 = 1'b1; else rst1 = 1'b1;
            #1;
            checkVal("abort_flags", int'({fin, suc, dv, ovf}), 0);
            checkVal("abort_index", int'(mi), 0);
            @(negedge clock);
            return;
        end

        while (!fin && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        checkVal("finish_latency", lat, nExp + 1);
        checkVal("drain_delay", int'(dv), 0);

        firstBad = -1;
        for (int i = 0; i < nExp; i++) begin
            if ((firstBad < 0) && ((i >= mCnt) || (bm[i] != expv[i]))) firstBad = i;
        end
        if (firstBad >= 0) expMi = firstBad;
        else if (mCnt != nExp) expMi = (mCnt < nExp - 1) ? mCnt : nExp - 1;
        else expMi = 0;
        expSuc = (firstBad < 0) && (mCnt == nExp) && !mOv;

        checkVal("finished", int'(fin), 1);
        checkVal("success", int'(suc), int'(expSuc));
        checkVal("mismatch_index", int'(mi), expMi);
        checkVal("overflow", int'(ovf), int'(mOv));

        guard = 0; xfers = 0; stallCycles = 0; held = -1;
        while ((sbQ.size() > 0) && (guard < 100)) begin
            drainReady = !(stall && (xfers == 1) && (stallCycles < 3));
            if (dv) begin
                if (drainReady) begin
                    checkVal("drain_word", int'(dd), sbQ.pop_front());
                    xfers++;
                    held = -1;
                end else begin
                    stallCycles++;
                    if (held >= 0) checkVal("drain_stable", int'(dd), held);
                    held = int'(dd);
                end
            end
            @(negedge clock);
            guard++;
        end
        drainReady = 1'b1;
        checkVal("drain_left", sbQ.size(), 0);
        checkVal("drain_end", int'(dv), 0);
        @(negedge clock);
        checkVal("drain_quiet", int'(dv), 0);
        checkVal("finished_hold", int'(fin), 1);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
        outValid = 1'b0; outData = 12'd0; expValid = 1'b0; expIdx = 2'd0; expData = 12'd0;
        progFinished = 1'b0; drainReady = 1'b1;
        repeat (2) @(negedge clock);

        // shift-left program
        runProgram(0, 1, 100, 1'b1, 12'h002, 32'h0000_0002, 1, 1'b0, 1'b0);
        // mismatch at index 1, with drain backpressure
        runProgram(1, 3, 4, 1'b1, 12'h321, 32'h0000_0351, 3, 1'b1, 1'b0);
        // short output
        runProgram(1, 3, 4, 1'b1, 12'h444, 32'h0000_0004, 1, 1'b0, 1'b0);
        // overflow, oldest-first drain with backpressure
        runProgram(1, 3, 4, 1'b1, 12'h321, 32'h0065_4321, 6, 1'b1, 1'b0);
        // too many words but all compared ones match: index clamps
        runProgram(1, 3, 4, 1'b1, 12'h321, 32'h0000_4321, 4, 1'b0, 1'b0);
        // reset mid-CHECK, then a run without reloading the table, then a clean pass
        runProgram(1, 3, 4, 1'b1, 12'h321, 32'h0065_4321, 6, 1'b0, 1'b1);
        runProgram(1, 3, 4, 1'b0, 12'h000, 32'h0000_0321, 3, 1'b0, 1'b0);
        runProgram(1, 3, 4, 1'b1, 12'h321, 32'h0000_0321, 3, 1'b1, 1'b0);
        // reset mid-CHECK on the default instance, then shift-left again
        runProgram(0, 1, 100, 1'b1, 12'h002, 32'h0000_0002, 1, 1'b0, 1'b1);
        runProgram(0, 1, 100, 1'b1, 12'h002, 32'h0000_0002, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
